// File: rtl/uart_8n1_rx_buffer.sv
// Purpose: arms an 8N1 receiver, commits good bytes into a circular FWFT FIFO, counts bad frames.
// Latency: busy falls at edge E0 -> byte visible after E1 -> earliest re-arm (recv_read=1) after E2.
// Backpressure: out_valid/out_ready on the consumer side; the receiver is never armed while the FIFO would stay full.
//
// Ports:
//   clk_baud_16x  16x baud clock shared with the receiver
//   reset_n       asynchronous active-low reset
//   rx_enable     keep re-arming the receiver while high
//   recv_data     receiver byte, valid when recv_busy falls
//   recv_busy     receiver busy
//   recv_error    receiver framing/sampling error flag
//   recv_read     registered one-cycle start pulse to the receiver
//   out_data      FIFO head byte (first-word-fall-through)
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts out_data when out_valid=1
//   fifo_count    bytes currently stored, 0..DEPTH
//   err_count     saturating count of failed frames
//   err_clear     zero err_count (applied before a same-cycle increment)
module uart_8n1_rx_buffer #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_baud_16x,
  input  logic                  reset_n,
  input  logic                  rx_enable,
  input  logic [7:0]            recv_data,
  input  logic                  recv_busy,
  input  logic                  recv_error,
  output logic                  recv_read,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [7:0]            err_count,
  input  logic                  err_clear
);

  localparam int                 DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT_BUSY,
    RECEIVING
  } state_e;

  state_e                  state_q;
  logic                    recv_read_q;
  logic                    wait_cnt_q;

  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [7:0]              err_q, err_d;

  logic [7:0]              mem [DEPTH];

  logic                    commit;
  logic                    push;
  logic                    pop;

  // The receiver has just dropped busy: this is the single cycle in which
  // recv_data/recv_error are taken.
  assign commit = (state_q == RECEIVING) && !recv_busy;
  assign push   = commit && !recv_error;
  assign pop    = (count_q != '0) && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first so that clear plus a same-cycle error lands on 1.
    if (err_clear) err_d = 8'h00;
    if (commit && recv_error && (err_d != 8'hff)) err_d = err_d + 8'h01;
  end

  // Control FSM. recv_read is registered and high exactly while in ARM.
  // count_d already accounts for a pop this cycle, so a consumer draining a
  // full FIFO lets the receiver be armed without a bubble.
  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      recv_read_q <= 1'b0;
      wait_cnt_q  <= 1'b0;
    end else begin
      recv_read_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_enable && (count_d < DEPTH_CNT)) begin
            state_q     <= ARM;
            recv_read_q <= 1'b1;
          end
        end
        ARM: begin
          state_q    <= WAIT_BUSY;
          wait_cnt_q <= 1'b0;
        end
        WAIT_BUSY: begin
          // A receiver held in reset never raises busy; give up after two cycles.
          if (recv_busy) begin
            state_q <= RECEIVING;
          end else if (wait_cnt_q) begin
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= 1'b1;
          end
        end
        RECEIVING: begin
          // Deasserting rx_enable here does not abort the frame.
          if (!recv_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk_baud_16x) begin
    if (push) mem[wr_ptr_q] <= recv_data;
  end

  assign recv_read  = recv_read_q;
  assign out_data   = mem[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign fifo_count = count_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_uart_8n1_rx_buffer.sv
module tb_uart_8n1_rx_buffer;

  logic       clk;
  logic       reset_n;
  logic       rx_enable;
  logic [7:0] recv_data;
  logic       recv_busy;
  logic       recv_error;
  logic       recv_read;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fifo_count;
  logic [7:0] err_count;
  logic       err_clear;

  int checks = 0;
  int errors = 0;

  uart_8n1_rx_buffer #(.DEPTH_LOG2(3)) dut (
    .clk_baud_16x (clk),
    .reset_n      (reset_n),
    .rx_enable    (rx_enable),
    .recv_data    (recv_data),
    .recv_busy    (recv_busy),
    .recv_error   (recv_error),
    .recv_read    (recv_read),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_count   (fifo_count),
    .err_count    (err_count),
    .err_clear    (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural receiver: waits (bounded) for recv_read, raises busy, then
  // drops busy with the frame result. Returns one negedge after the commit edge.
  task automatic send_frame(input logic [7:0] d, input logic e, input logic clr,
                            input logic rdy, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (recv_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      recv_busy = 1'b1;
      repeat (4) @(negedge clk);
      recv_data  = d;
      recv_error = e;
      recv_busy  = 1'b0;
      if (clr) err_clear = 1'b1;
      if (rdy) out_ready = 1'b1;
      @(negedge clk);
      if (clr) err_clear = 1'b0;
      if (rdy) out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if (recv_read !== 1'b0) begin errors++; $display("FAIL reset_recv_read got %0b exp 0", recv_read); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
  endtask

  task automatic test_single();
    logic ok;
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_armed got %0b exp 1", ok); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_out_data got %02h exp a5", out_data); end
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_fifo_count got %0d exp 1", fifo_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL single_err_count got %0d exp 0", err_count); end
    checks++; if (recv_read !== 1'b0) begin errors++; $display("FAIL single_rearm_early got %0b exp 0", recv_read); end
    @(negedge clk);
    checks++; if (recv_read !== 1'b1) begin errors++; $display("FAIL single_rearm_e2 got %0b exp 1", recv_read); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_drain got %0d exp 0", fifo_count); end
  endtask

  task automatic test_fill();
    logic ok;
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b0, ok);
      if (i < 8) begin
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fill_armed_%0d got %0b exp 1", i, ok); end
      end else begin
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL fill_ninth_armed got %0b exp 0", ok); end
      end
    end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", fifo_count); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid_%0d got %0b exp 1", k, out_valid); end
      checks++; if (out_data !== 8'(k)) begin errors++; $display("FAIL drain_data_%0d got %02h exp %02h", k, out_data, k); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_error();
    logic ok;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL error_armed got %0b exp 1", ok); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL error_count got %0d exp 0", fifo_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL error_valid got %0b exp 0", out_valid); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL error_err_count got %0d exp 1", err_count); end
  endtask

  task automatic test_saturate();
    logic ok;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clear_alone got %0d exp 0", err_count); end
    for (int i = 0; i < 254; i++) send_frame(8'hFF, 1'b1, 1'b0, 1'b0, ok);
    checks++; if (err_count !== 8'hfe) begin errors++; $display("FAIL sat_254 got %02h exp fe", err_count); end
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, ok);
    checks++; if (err_count !== 8'hff) begin errors++; $display("FAIL sat_255 got %02h exp ff", err_count); end
    for (int i = 0; i < 5; i++) send_frame(8'hFF, 1'b1, 1'b0, 1'b0, ok);
    checks++; if (err_count !== 8'hff) begin errors++; $display("FAIL sat_260 got %02h exp ff", err_count); end
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, ok);
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL clear_with_error got %0d exp 1", err_count); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL sat_no_push got %0d exp 0", fifo_count); end
  endtask

  task automatic test_stream();
    logic ok;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, ok);
      checks++; if (out_data !== 8'h40 + 8'(i) || out_valid !== 1'b1) begin
        errors++; $display("FAIL stream_data_%0d got %02h/%0b exp %02h/1", i, out_data, out_valid, 8'h40 + 8'(i));
      end
      checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL stream_count_%0d got %0d exp 1", i, fifo_count); end
      @(negedge clk);
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL stream_popped_%0d got %0d exp 0", i, fifo_count); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    logic ok;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, ok);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, ok);
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL pushpop_count got %0d exp 1", fifo_count); end
    checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL pushpop_head got %02h exp 22", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL pushpop_drain got %0d exp 0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic seen;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(8'h70 + 8'(i), 1'b0, 1'b0, 1'b0, ok);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 3", fifo_count); end
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (recv_read === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_armed got %0b exp 1", seen); end
    recv_busy = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    recv_busy = 1'b0;
    #1;
    checks++; if (recv_read !== 1'b0) begin errors++; $display("FAIL rstmid_recv_read got %0b exp 0", recv_read); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %0b exp 0", out_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rstmid_fifo_count got %0d exp 0", fifo_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rstmid_err_count got %0d exp 0", err_count); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      if (recv_read === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_rearm got %0b exp 1", seen); end
  endtask

  initial begin
    reset_n    = 1'b0;
    rx_enable  = 1'b0;
    recv_data  = 8'h00;
    recv_busy  = 1'b0;
    recv_error = 1'b0;
    out_ready  = 1'b0;
    err_clear  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    rx_enable = 1'b1;
    test_single();
    test_fill();
    test_error();
    test_saturate();
    test_stream();
    test_push_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
